scan_decoder: RTL and testbench

Parametrised, registered binary-to-N-line decoder, the next generation of the team's combinational 4-to-16 decoder with enable. It adds registered outputs, a thermometer mode, and an autonomous scan mode that walks the active line 0..scan_last with a programmable dwell. It sits in front of multiplexed displays, keypad column strobes and bank-select fan-outs.

---
 rtl/scan_decoder.sv | 132 +++++++++++++
 tb/tb_scan_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-N-line decoder with one-hot, thermometer,
// autonomous scan and hold modes. All outputs come straight from flops.
module scan_decoder #(
    parameter int unsigned IN_W    = 4,
    parameter int unsigned DWELL_W = 8,
    localparam int unsigned OUT_W  = 2 ** IN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [IN_W-1:0]    binary_in,
    input  logic [IN_W-1:0]    scan_last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   decoder_out,
    output logic [IN_W-1:0]    index_out,
    output logic               valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    mode_e              w_mode;
    mode_e              r_prev_mode;
    logic [OUT_W-1:0]   r_dec;
    logic [IN_W-1:0]    r_index;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_wrap;

    logic [OUT_W-1:0]   w_dec_nxt;
    logic [IN_W-1:0]    w_index_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;

    function automatic logic [OUT_W-1:0] f_onehot(input logic [IN_W-1:0] idx);
        return OUT_W'(1) << idx;
    endfunction

    // Lines 0..idx inclusive are set.
    function automatic logic [OUT_W-1:0] f_therm(input logic [IN_W-1:0] idx);
        logic [OUT_W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            t[i] = (i <= 32'(idx));
        end
        return t;
    endfunction

    assign w_mode = mode_e'(mode);

    // Next-state and next-output selection; every target defaults to hold, wrap to 0.
    always_comb begin
        w_dec_nxt   = r_dec;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_wrap_nxt  = 1'b0;

        if (!enable) begin
            // Blank the lines; index and dwell counter stay put so scan resumes.
            w_dec_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (w_mode)
                MODE_ONEHOT: begin
                    w_index_nxt = binary_in;
                    w_dec_nxt   = f_onehot(binary_in);
                    w_valid_nxt = 1'b1;
                end
                MODE_THERM: begin
                    w_index_nxt = binary_in;
                    w_dec_nxt   = f_therm(binary_in);
                    w_valid_nxt = 1'b1;
                end
                MODE_SCAN: begin
                    if (r_prev_mode != MODE_SCAN) begin
                        w_index_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= dwell) begin
                        // >= so a dwell lowered below the count advances right away.
                        w_cnt_nxt = '0;
                        if (r_index >= scan_last) begin
                            w_index_nxt = '0;
                            w_wrap_nxt  = 1'b1;
                        end else begin
                            w_index_nxt = r_index + IN_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + DWELL_W'(1);
                    end
                    w_dec_nxt   = f_onehot(w_index_nxt);
                    w_valid_nxt = 1'b1;
                end
                default: begin
                    // MODE_HOLD: everything frozen, wrap already forced low.
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec       <= '0;
            r_index     <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_prev_mode <= MODE_ONEHOT;
        end else begin
            r_dec       <= w_dec_nxt;
            r_index     <= w_index_nxt;
            r_cnt       <= w_cnt_nxt;
            r_valid     <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
            r_prev_mode <= w_mode;
        end
    end

    assign decoder_out = r_dec;
    assign index_out   = r_index;
    assign valid       = r_valid;
    assign wrap        = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: scoreboard bench; driver pushes model predictions, monitor pops and compares.
module tb_scan_decoder;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [3:0]  binary_in;
    logic [3:0]  scan_last;
    logic [7:0]  dwell;
    logic [15:0] decoder_out;
    logic [3:0]  index_out;
    logic        valid;
    logic        wrap;

    scan_decoder #(.IN_W(4), .DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .binary_in  (binary_in),
        .scan_last  (scan_last),
        .dwell      (dwell),
        .decoder_out(decoder_out),
        .index_out  (index_out),
        .valid      (valid),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dec;
        logic [3:0]  idx;
        logic        vld;
        logic        wrp;
        int          step;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    // Behavioural reference state (plain integers).
    int m_idx = 0, m_cnt = 0, m_prev = 0, m_dec = 0, m_valid = 0, m_wrap = 0;

    task automatic model_step(input bit r, input bit e, input int m, input int b,
                              input int l, input int d);
        exp_t x;
        if (r) begin
            m_idx = 0; m_cnt = 0; m_prev = 0; m_dec = 0; m_valid = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (!e) begin
                m_dec = 0; m_valid = 0;
            end else begin
                case (m)
                    0: begin m_idx = b; m_dec = 1 << b; m_valid = 1; end
                    1: begin m_idx = b; m_dec = (1 << (b + 1)) - 1; m_valid = 1; end
                    2: begin
                        if (m_prev != 2) begin
                            m_idx = 0; m_cnt = 0;
                        end else if (m_cnt >= d) begin
                            m_cnt = 0;
                            if (m_idx >= l) begin m_idx = 0; m_wrap = 1; end
                            else m_idx = m_idx + 1;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                        m_dec = 1 << m_idx; m_valid = 1;
                    end
                    default: ;
                endcase
            end
            m_prev = m;
        end
        x.dec = 16'(m_dec); x.idx = 4'(m_idx); x.vld = 1'(m_valid); x.wrp = 1'(m_wrap);
        x.step = step_no;
        q.push_back(x);
    endtask

    task automatic drive(input bit r, input bit e, input int m, input int b,
                         input int l, input int d);
        @(negedge clk);
        step_no   = step_no + 1;
        rst       = r;
        enable    = e;
        mode      = 2'(m);
        binary_in = 4'(b);
        scan_last = 4'(l);
        dwell     = 8'(d);
        model_step(r, e, m, b, l, d);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_checks = n_checks + 4;
                if (decoder_out !== x.dec) begin
                    n_errors++;
                    $display("FAIL decoder_out step %0d: got %h expected %h", x.step, decoder_out, x.dec);
                end
                if (index_out !== x.idx) begin
                    n_errors++;
                    $display("FAIL index_out step %0d: got %0d expected %0d", x.step, index_out, x.idx);
                end
                if (valid !== x.vld) begin
                    n_errors++;
                    $display("FAIL valid step %0d: got %b expected %b", x.step, valid, x.vld);
                end
                if (wrap !== x.wrp) begin
                    n_errors++;
                    $display("FAIL wrap step %0d: got %b expected %b", x.step, wrap, x.wrp);
                end
            end
        end
    end

    initial begin
        int m, b, l, d;
        bit e, r;
        rst = 1'b1; enable = 1'b0; mode = 2'b00; binary_in = '0; scan_last = '0; dwell = '0;

        // Reset with direct one-hot index 5 pending, then release.
        drive(1, 1, 0, 5, 0, 0);
        drive(1, 1, 0, 5, 0, 0);
        drive(0, 1, 0, 5, 0, 0);

        // Direct one-hot sweep, then blank.
        for (int i = 0; i < 16; i++) drive(0, 1, 0, i, 0, 0);
        drive(0, 0, 0, 15, 0, 0);

        // Thermometer points.
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 3, 0, 0);
        drive(0, 1, 1, 15, 0, 0);

        // Scan dwell=2 last=3, run until index 2 with count 1.
        for (int i = 0; i < 20; i++) drive(0, 1, 2, 0, 3, 2);
        // Pause three cycles, resume one, then hold.
        for (int i = 0; i < 3; i++) drive(0, 0, 2, 0, 3, 2);
        drive(0, 1, 2, 0, 3, 2);
        for (int i = 0; i < 3; i++) drive(0, 1, 3, 0, 3, 2);

        // dwell=0, scan_last=0: line 0 steady, wrap each cycle (entry from hold).
        for (int i = 0; i < 6; i++) drive(0, 1, 2, 0, 0, 0);
        // Climb to index 3 with last=3 then lower last to 1.
        for (int i = 0; i < 3; i++) drive(0, 1, 2, 0, 3, 0);
        drive(0, 1, 2, 0, 1, 0);
        drive(0, 1, 2, 0, 1, 0);
        // Reset mid-scan and restart.
        for (int i = 0; i < 4; i++) drive(0, 1, 2, 0, 7, 1);
        drive(1, 1, 2, 0, 7, 1);
        for (int i = 0; i < 8; i++) drive(0, 1, 2, 0, 7, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            m = (i % 300 < 150) ? 2 : int'($urandom_range(0, 3));
            b = int'($urandom_range(0, 15));
            l = int'($urandom_range(0, 15));
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            drive(r, e, m, b, l, d);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
